// File: rtl/alu_req_arbiter.sv
// Two-requester arbiter in front of one shared bitwise logic unit.
// Each request is granted, executed and answered in a fixed three-cycle sequence.
module alu_req_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [1:0]   req,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] b0,
    input  logic [1:0]   op0,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] b1,
    input  logic [1:0]   op1,
    output logic [1:0]   gnt,
    output logic [1:0]   done,
    output logic [N-1:0] result,
    output logic         flagZ,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state;
    logic         ptr;
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic [1:0]   op_q;
    logic [N-1:0] unit;
    logic         pick1;

    // Requester 1 wins when it is alone, or when both ask and the pointer names it
    always_comb begin
        pick1 = req[1] & (~req[0] | ptr);
    end

    // Shared logic unit working only on the latched operands
    always_comb begin
        unit = '0;
        case (op_q)
            2'b00:   unit = a_q & b_q;
            2'b01:   unit = a_q | b_q;
            2'b10:   unit = a_q ^ b_q;
            default: unit = ~(a_q & b_q);
        endcase
    end

    assign busy = (state != IDLE);

    // Sequencer: grant and latch in IDLE, compute in EXEC, pulse done in RESP
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= 1'b0;
            gnt    <= 2'b00;
            done   <= 2'b00;
            result <= '0;
            flagZ  <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    done <= 2'b00;
                    if (|req) begin
                        gnt   <= pick1 ? 2'b10 : 2'b01;
                        a_q   <= pick1 ? a1 : a0;
                        b_q   <= pick1 ? b1 : b0;
                        op_q  <= pick1 ? op1 : op0;
                        state <= EXEC;
                    end
                end
                EXEC: begin
                    result <= unit;
                    flagZ  <= (unit == '0);
                    done   <= gnt;
                    state  <= RESP;
                end
                RESP: begin
                    done  <= 2'b00;
                    gnt   <= 2'b00;
                    ptr   <= gnt[0];
                    state <= IDLE;
                end
                default: begin
                    done  <= 2'b00;
                    gnt   <= 2'b00;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with hand-computed expectations.
// Outputs are sampled 1 time unit after each rising edge.
module tb_alu_req_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] req = 2'b00;
    logic [3:0] a0 = 4'h0;
    logic [3:0] b0 = 4'h0;
    logic [1:0] op0 = 2'b00;
    logic [3:0] a1 = 4'h0;
    logic [3:0] b1 = 4'h0;
    logic [1:0] op1 = 2'b00;
    logic [1:0] gnt;
    logic [1:0] done;
    logic [3:0] result;
    logic       flagZ;
    logic       busy;

    int checks = 0;
    int failures = 0;

    alu_req_arbiter #(.N(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .a0     (a0),
        .b0     (b0),
        .op0    (op0),
        .a1     (a1),
        .b1     (b1),
        .op1    (op1),
        .gnt    (gnt),
        .done   (done),
        .result (result),
        .flagZ  (flagZ),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'h0);
        chk({tag, "_done"}, 32'(done), 32'h0);
        chk({tag, "_busy"}, 32'(busy), 32'h0);
    endtask

    logic [1:0] exp_g;

    initial begin
        // Reset state
        tick();
        tick();
        chk_idle("rst");
        chk("rst_result", 32'(result), 32'h0);
        chk("rst_flagZ", 32'(flagZ), 32'h0);
        #2 rst_n = 1'b1;

        // Requester 0 alone: 1100 AND 1010 = 1000
        req = 2'b01; a0 = 4'b1100; b0 = 4'b1010; op0 = 2'b00;
        tick();
        chk("s1_gnt", 32'(gnt), 32'h1);
        chk("s1_busy", 32'(busy), 32'h1);
        chk("s1_nodone", 32'(done), 32'h0);
        tick();
        chk("s1_done", 32'(done), 32'h1);
        chk("s1_result", 32'(result), 32'h8);
        chk("s1_flagZ", 32'(flagZ), 32'h0);
        req = 2'b00;
        tick();
        chk_idle("s1_idle");
        chk("s1_hold", 32'(result), 32'h8);

        // Requester 1 alone: 0101 AND 1010 = 0000
        req = 2'b10; a1 = 4'b0101; b1 = 4'b1010; op1 = 2'b00;
        tick();
        chk("s2_gnt", 32'(gnt), 32'h2);
        tick();
        chk("s2_done", 32'(done), 32'h2);
        chk("s2_result", 32'(result), 32'h0);
        chk("s2_flagZ", 32'(flagZ), 32'h1);
        req = 2'b00;
        tick();
        chk_idle("s2_idle");

        // Same operands, NAND: ~(0000) = 1111
        req = 2'b10; op1 = 2'b11;
        tick();
        chk("s2b_gnt", 32'(gnt), 32'h2);
        tick();
        chk("s2b_done", 32'(done), 32'h2);
        chk("s2b_result", 32'(result), 32'hF);
        chk("s2b_flagZ", 32'(flagZ), 32'h0);
        req = 2'b00;
        tick();
        chk_idle("s2b_idle");

        // Both requesting after reset: grants alternate 0,1,0,1
        rst_n = 1'b0;
        tick();
        #2 rst_n = 1'b1;
        a0 = 4'b0011; b0 = 4'b0101; op0 = 2'b01;
        a1 = 4'b0011; b1 = 4'b0101; op1 = 2'b10;
        req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            tick();
            chk($sformatf("rr%0d_gnt", i), 32'(gnt), 32'(exp_g));
            chk($sformatf("rr%0d_pre", i), 32'(done), 32'h0);
            tick();
            chk($sformatf("rr%0d_done", i), 32'(done), 32'(exp_g));
            chk($sformatf("rr%0d_result", i), 32'(result),
                (i % 2 == 0) ? 32'h7 : 32'h6);
            if (i == 3) req = 2'b00;
            tick();
            chk_idle($sformatf("rr%0d_idle", i));
        end
        tick();
        chk_idle("rr_quiet");

        // Operand change during EXEC is ignored: 1111 XOR 1111 = 0000
        req = 2'b01; a0 = 4'b1111; b0 = 4'b1111; op0 = 2'b10;
        tick();
        chk("s4_gnt", 32'(gnt), 32'h1);
        a0 = 4'b0000;
        tick();
        chk("s4_done", 32'(done), 32'h1);
        chk("s4_result", 32'(result), 32'h0);
        chk("s4_flagZ", 32'(flagZ), 32'h1);
        req = 2'b00;
        tick();
        chk_idle("s4_idle");

        // Reset during EXEC of a grant to requester 1 aborts with no done
        req = 2'b10; a1 = 4'b0011; b1 = 4'b0101; op1 = 2'b01;
        tick();
        chk("s5_gnt", 32'(gnt), 32'h2);
        #1 rst_n = 1'b0;
        #1;
        chk_idle("s5_abort");
        chk("s5_result", 32'(result), 32'h0);
        chk("s5_flagZ", 32'(flagZ), 32'h0);
        tick();
        chk("s5_nodone", 32'(done), 32'h0);
        // Both requesting at release: reset pointer favours requester 0
        req = 2'b11; a0 = 4'b0110; b0 = 4'b0011; op0 = 2'b00;
        #2 rst_n = 1'b1;
        tick();
        chk("s5_first", 32'(gnt), 32'h1);

        // Requester 0 drops req in EXEC, done still pulses exactly once
        req = 2'b00;
        tick();
        chk("s6_done", 32'(done), 32'h1);
        chk("s6_result", 32'(result), 32'h2);
        chk("s6_flagZ", 32'(flagZ), 32'h0);
        tick();
        chk_idle("s6_idle");
        tick();
        chk_idle("s6_stay");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

endmodule

// File: doc/alu_req_arbiter.md
ALU_REQ_ARBITER -- requirements
Module: alu_req_arbiter

Interface
REQ-001 Parameter N, default 4: operand and result width in bits.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 req  input  2  per-requester request level; req[i] held high until done[i].
REQ-005 a0, b0  input  N each  requester 0 operands.
REQ-006 op0  input  2  requester 0 opcode: 00 AND, 01 OR, 10 XOR, 11 NAND.
REQ-007 a1, b1  input  N each  requester 1 operands.
REQ-008 op1  input  2  requester 1 opcode, same encoding as op0.
REQ-009 gnt  output  2  one-hot grant; marks the requester currently owning the unit.
REQ-010 done  output  2  one-cycle completion pulse to the granted requester.
REQ-011 result  output  N  shared registered result bus; valid while done is nonzero.
REQ-012 flagZ  output  1  registered zero flag; 1 when result equals 0.
REQ-013 busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 The block SHALL contain one shared logic unit computing a&b, a|b, a^b or ~(a&b) on latched operands, with full N-bit width and no carry.
REQ-015 The FSM SHALL have exactly three states: IDLE, EXEC and RESP.
REQ-016 In IDLE with req==00, the FSM SHALL stay in IDLE, and gnt, done and busy SHALL be 0.
REQ-017 In IDLE with any req bit high, the block SHALL select one requester, latch its a, b and op, set gnt one-hot for it and move to EXEC on that edge.
REQ-018 When only one req bit is high, that requester SHALL be selected.
REQ-019 When both req bits are high, the requester named by the round-robin pointer SHALL be selected.
REQ-020 The round-robin pointer SHALL switch to the other requester after every completed grant.
REQ-021 In EXEC, the unit output SHALL be registered into result, flagZ SHALL be registered as (unit output == 0), and the FSM SHALL move to RESP.
REQ-022 In RESP, done SHALL equal gnt for exactly one cycle, and the FSM SHALL return to IDLE on the next edge.
REQ-023 gnt SHALL be cleared on the edge that enters IDLE.
REQ-024 Latency SHALL be fixed: done is asserted in the second cycle after the grant edge, giving one transaction per 3 cycles.
REQ-025 After done, the FSM SHALL spend at least one cycle in IDLE before any new grant.
REQ-026 Operand or opcode changes after the grant edge SHALL NOT affect the transaction in progress.
REQ-027 If the granted requester drops req mid-transaction, the transaction SHALL still complete and done SHALL still pulse.
REQ-028 A requester holding req through its done pulse SHALL be treated as a new request in the following IDLE cycle, subject to the round-robin pointer.
REQ-029 result and flagZ SHALL hold their last values outside RESP until the next EXEC.
REQ-030 gnt SHALL never have both bits set, and done SHALL never be nonzero outside RESP.

Reset
REQ-031 While rst_n=0, the block SHALL force state=IDLE, gnt=00, done=00, result=0, flagZ=0 and busy=0.
REQ-032 While rst_n=0, the round-robin pointer SHALL favour requester 0, and the latched operands SHALL be cleared.
REQ-033 Reset asserted during EXEC or RESP SHALL abort the transaction immediately with no done pulse.
REQ-034 The first edge with rst_n=1 SHALL behave as an IDLE cycle.

Verification
REQ-035 The bench SHALL cover the following directed scenarios:
- N=4; req=01, a0=1100, b0=1010, op0=00 -> gnt=01 one cycle after the sampling edge; done=01 two cycles later with result=1000, flagZ=0.
- req=10, a1=0101, b1=1010, op1=00 -> result=0000, flagZ=1, done=10; then op1=11 with the same operands -> result=1111, flagZ=0.
- req=11 held for 4 transactions after reset -> grant order 0,1,0,1; done pulses alternate 01,10,01,10, each separated by 3 cycles.
- Grant to 0 with a0=1111, b0=1111, op0=10; change a0 to 0000 during EXEC -> result=0000 from the latched operands, flagZ=1.
- Grant to 1, then rst_n=0 during EXEC -> done stays 00, and all outputs are 0 within the same cycle; after release, req=01 is served first.
- Requester 0 drops req in RESP-1 -> done=01 still pulses once; the next IDLE with req=00 keeps busy=0.
